mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_pkg.sv | 36 +++
 rtl/mem_bist_if.sv | 31 +++
 rtl/mem_bist_cmp.sv | 101 ++++++++++
 rtl/mem_bist_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bist_pkg.sv
// ============================================================================
// Module : mem_bist_pkg
// Brief  : Shared types, constants and pattern helpers for the march-style BIST.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_R0   = 3'd2,
        ST_D0   = 3'd3,
        ST_W1   = 3'd4,
        ST_R1   = 3'd5,
        ST_D1   = 3'd6,
        ST_DONE = 3'd7
    } bist_state_e;

    typedef enum logic {
        PH0 = 1'b0,
        PH1 = 1'b1
    } bist_phase_e;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;
    localparam int         PAT_W       = 64;

    // Address zero-extended to PAT_W; callers keep the low DATA_WIDTH bits.
    function automatic logic [PAT_W-1:0] pat(input logic [31:0] a);
        return {32'b0, a};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bist_if.sv
// ============================================================================
// Module : mem_bist_if
// Brief  : Single-port RAM bus between the BIST controller and the memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_bist_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cs;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ecccorr;
    logic                  eccderr;

    modport master (
        output cs, we, addr, wr_data,
        input  rd_data, ecccorr, eccderr
    );

    modport slave (
        input  cs, we, addr, wr_data,
        output rd_data, ecccorr, eccderr
    );
endinterface

`default_nettype wire

// File: rtl/mem_bist_cmp.sv
// ============================================================================
// Module : mem_bist_cmp
// Brief  : Read-latency pipeline, data comparator, saturating error counter
//          and first-fail capture. ECC check gated by MEM_BIST_ECC_CHK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bist_cmp
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  clr_i,
    input  wire logic                  flush_i,
    input  wire logic                  issue_i,
    input  wire logic [ADDR_WIDTH-1:0] addr_i,
    input  wire logic [DATA_WIDTH-1:0] exp_i,
    input  wire logic [DATA_WIDTH-1:0] rd_data_i,
    input  wire logic                  ecccorr_i,
    input  wire logic                  eccderr_i,
    output logic                       mism_o,
    output logic [7:0]                 err_count_o,
    output logic [ADDR_WIDTH-1:0]      fail_addr_o,
    output logic [DATA_WIDTH-1:0]      fail_data_o
);

    localparam int LAST = RD_LATENCY - 1;

    logic                  vld_q  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] exp_q  [RD_LATENCY];
    logic [7:0]            err_cnt_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_data_q;
    logic                  w_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_q[i]  <= 1'b0;
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
            end
        end else begin
            vld_q[0]  <= issue_i & ~flush_i;
            addr_q[0] <= addr_i;
            exp_q[0]  <= exp_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1] & ~flush_i;
                addr_q[i] <= addr_q[i-1];
                exp_q[i]  <= exp_q[i-1];
            end
        end
    end

`ifdef MEM_BIST_ECC_CHK_EN
    // A double-bit ECC error fails the compare even when the data happens to match.
    logic w_unused_ecc;
    assign w_unused_ecc = ecccorr_i;
    assign w_bad        = (rd_data_i != exp_q[LAST]) || eccderr_i;
`else
    logic w_unused_ecc;
    assign w_unused_ecc = ecccorr_i ^ eccderr_i;
    assign w_bad        = (rd_data_i != exp_q[LAST]);
`endif

    assign mism_o = vld_q[LAST] && w_bad;

    // err_count==0 doubles as "no failure captured yet" since it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q   <= 8'd0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (clr_i) begin
            err_cnt_q   <= 8'd0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (mism_o && !flush_i) begin
            if (err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (err_cnt_q == 8'd0) begin
                fail_addr_q <= addr_q[LAST];
                fail_data_q <= rd_data_i;
            end
        end
    end

    assign err_count_o = err_cnt_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;

endmodule

`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
// ============================================================================
// Module : mem_bist_ctrl
// Brief  : March BIST sequencer (W0,R0,W1,R1) with registered RAM outputs.
//          Optional ECC double-error checking: define MEM_BIST_ECC_CHK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic                  abort,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [7:0]                 err_count,
    output logic [ADDR_WIDTH-1:0]      fail_addr,
    output logic [DATA_WIDTH-1:0]      fail_data,
    mem_bist_if.master                 mem
);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_W0   = ST_W0;
    localparam logic [2:0] S_R0   = ST_R0;
    localparam logic [2:0] S_D0   = ST_D0;
    localparam logic [2:0] S_W1   = ST_W1;
    localparam logic [2:0] S_R1   = ST_R1;
    localparam logic [2:0] S_D1   = ST_D1;
    localparam logic [2:0] S_DONE = ST_DONE;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = {ADDR_WIDTH{1'b1}};
    localparam logic [2:0]            DRAIN_LAST = 3'(RD_LATENCY - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cs_q, cs_d, we_q, we_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [2:0]            drain_q, drain_d;
    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic                  w_clr, w_flush, w_mism, w_busy_st;
    bist_phase_e           w_phase;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_exp;
    logic [7:0]            w_err_cnt;

    function automatic logic [DATA_WIDTH-1:0] f_data(input logic [ADDR_WIDTH-1:0] a,
                                                     input bist_phase_e ph);
        logic [PAT_W-1:0] v;
        v = (ph == PH1) ? ~pat(32'(a)) : pat(32'(a));
        return v[DATA_WIDTH-1:0];
    endfunction

    assign w_phase    = (state_q inside {S_W1, S_R1, S_D1}) ? PH1 : PH0;
    assign w_addr_nxt = addr_q + ADDR_WIDTH'(1);
    assign w_busy_st  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign w_exp      = f_data(addr_q, w_phase);

    always_comb begin
        state_d   = state_q;
        addr_d    = '0;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        wr_data_d = '0;
        drain_d   = drain_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        w_clr     = 1'b0;
        w_flush   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_W0;
                    cs_d      = 1'b1;
                    we_d      = 1'b1;
                    wr_data_d = f_data('0, PH0);
                    pass_d    = 1'b0;
                    w_clr     = 1'b1;
                end
            end
            S_W0, S_W1: begin
                cs_d = 1'b1;
                if (addr_q == ADDR_MAX) begin
                    state_d = (state_q == S_W0) ? S_R0 : S_R1;
                end else begin
                    addr_d    = w_addr_nxt;
                    we_d      = 1'b1;
                    wr_data_d = f_data(w_addr_nxt, w_phase);
                end
            end
            S_R0, S_R1: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = (state_q == S_R0) ? S_D0 : S_D1;
                    drain_d = 3'd0;
                end else begin
                    addr_d = w_addr_nxt;
                    cs_d   = 1'b1;
                end
            end
            S_D0, S_D1: begin
                if (drain_q == DRAIN_LAST) begin
                    if (state_q == S_D0) begin
                        state_d   = S_W1;
                        cs_d      = 1'b1;
                        we_d      = 1'b1;
                        wr_data_d = f_data('0, PH1);
                    end else begin
                        // Last compare retires on this edge, so fold it into pass.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (w_err_cnt == 8'd0) && !w_mism;
                    end
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (w_busy_st && abort) begin
            state_d   = S_IDLE;
            addr_d    = '0;
            cs_d      = 1'b0;
            we_d      = 1'b0;
            wr_data_d = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            w_flush   = 1'b1;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            wr_data_q <= '0;
            drain_q   <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            wr_data_q <= wr_data_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    mem_bist_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (w_clr),
        .flush_i     (w_flush),
        .issue_i     (cs_q & ~we_q),
        .addr_i      (addr_q),
        .exp_i       (w_exp),
        .rd_data_i   (mem.rd_data),
        .ecccorr_i   (mem.ecccorr),
        .eccderr_i   (mem.eccderr),
        .mism_o      (w_mism),
        .err_count_o (w_err_cnt),
        .fail_addr_o (fail_addr),
        .fail_data_o (fail_data)
    );

    assign mem.cs      = cs_q;
    assign mem.we      = we_q;
    assign mem.addr    = addr_q;
    assign mem.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = w_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
// ============================================================================
// Module : tb_mem_bist_ctrl
// Brief  : Directed bench for mem_bist_ctrl (latency 1 and 3 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_bist_ctrl;
    import mem_bist_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic       start1 = 1'b0, abort1 = 1'b0, busy1, done1, pass1;
    logic [7:0] err1, faddr1, fdata1;
    logic       start3 = 1'b0, abort3 = 1'b0, busy3, done3, pass3;
    logic [7:0] err3, faddr3, fdata3;

    mem_bist_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) m1 ();
    mem_bist_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) m3 ();

    mem_bist_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_addr(faddr1), .fail_data(fdata1), .mem(m1.master)
    );

    mem_bist_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_addr(faddr3), .fail_data(fdata3), .mem(m3.master)
    );

    // Latency-1 RAM with fault injection: mode 1 forces bit0 high at 0x10,
    // mode 2 holds bit7 at 0 on every read.
    logic [7:0] ram1 [256];
    logic [1:0] fmode   = 2'd0;
    logic       derr_on = 1'b0;
    logic       corr_on = 1'b0;
    logic [7:0] rd1;

    always_comb begin
        rd1 = ram1[m1.addr];
        if (fmode == 2'd1 && m1.addr == 8'h10) rd1[0] = 1'b1;
        if (fmode == 2'd2) rd1[7] = 1'b0;
    end

    always @(posedge clk) begin
        if (m1.cs && m1.we) ram1[m1.addr] <= m1.wr_data;
        if (m1.cs && !m1.we) begin
            m1.rd_data <= rd1;
            m1.eccderr <= derr_on && (m1.addr == 8'h20) && (ram1[m1.addr] == 8'h20);
            m1.ecccorr <= corr_on && (m1.addr == 8'h30);
        end
    end

    // Latency-3 fault-free RAM.
    logic [7:0] ram3 [256];
    logic [7:0] p3 [3];
    always @(posedge clk) begin
        if (m3.cs && m3.we) ram3[m3.addr] <= m3.wr_data;
        p3[0] <= ram3[m3.addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m3.rd_data = p3[2];
    assign m3.ecccorr = 1'b0;
    assign m3.eccderr = 1'b0;

    // Runs one test on dut1 from a negedge; watches the bus for address order,
    // write data pattern and quiet outputs while not busy.
    task automatic run1(input int abort_at, output int bcyc, output int dcnt,
                        output int merr, output int wcnt, output logic cs_ab,
                        output logic busy_ab);
        int rcnt;
        rcnt = 0; wcnt = 0; bcyc = 0; dcnt = 0; merr = 0;
        cs_ab = 1'b1; busy_ab = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            if (busy1) bcyc++;
            if (done1) dcnt++;
            if (m1.cs && m1.we) begin
                if (m1.addr !== 8'(wcnt) ||
                    m1.wr_data !== ((wcnt < 256) ? 8'(wcnt) : ~8'(wcnt))) merr++;
                wcnt++;
            end
            if (m1.cs && !m1.we) begin
                if (m1.addr !== 8'(rcnt)) merr++;
                rcnt++;
            end
            if (!busy1 && (m1.cs || m1.we || m1.addr != 8'd0 || m1.wr_data != 8'd0)) merr++;
            if (c == abort_at + 1) begin
                cs_ab   = m1.cs;
                busy_ab = busy1;
            end
            if (c == abort_at) abort1 = 1'b1;
            @(negedge clk);
            abort1 = 1'b0;
        end
    endtask

    initial begin
        int   bc, dc, me, wc;
        logic ca, ba;

        repeat (3) @(negedge clk);
        chk("rst_flags", {27'd0, busy1, done1, pass1, m1.cs, m1.we}, 32'd0);
        chk("rst_err_fail", {8'd0, err1, faddr1, fdata1}, 32'd0);
        chk("rst_bus", {16'd0, m1.addr, m1.wr_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free: 4*256+2*1 busy cycles.
        fmode = 2'd0;
        run1(-1, bc, dc, me, wc, ca, ba);
        chk("t1_busy_len", bc, 1026);
        chk("t1_done_cnt", dc, 1);
        chk("t1_bus_mon", me, 0);
        chk("t1_writes", wc, 512);
        chk("t1_pass", pass1, 1);
        chk("t1_err", err1, 0);

        // Bit0 forced at 0x10: R0 reads 0x11 instead of 0x10; R1 data 0xEF unaffected.
        fmode = 2'd1;
        run1(-1, bc, dc, me, wc, ca, ba);
        chk("t2_err", err1, 1);
        chk("t2_faddr", faddr1, 8'h10);
        chk("t2_fdata", fdata1, 8'h11);
        chk("t2_pass", pass1, 0);
        chk("t2_done_cnt", dc, 1);

        // Bit7 stuck at 0: 128 fails in R0 (0x80..0xFF) + 128 in R1 -> saturate;
        // first failing read is R0 at 0x80 returning 0x00.
        fmode = 2'd2;
        run1(-1, bc, dc, me, wc, ca, ba);
        chk("t3_err_sat", err1, 255);
        chk("t3_faddr", faddr1, 8'h80);
        chk("t3_fdata", fdata1, 8'h00);
        chk("t3_pass", pass1, 0);

        // Abort at cycle 300 (inside R0, after the 0x10 failure at cycle 273).
        fmode = 2'd1;
        run1(300, bc, dc, me, wc, ca, ba);
        chk("t4_cs_after_abort", ca, 0);
        chk("t4_busy_after_abort", ba, 0);
        chk("t4_busy_len", bc, 301);
        chk("t4_no_done", dc, 0);
        chk("t4_err_held", err1, 1);
        chk("t4_faddr_held", faddr1, 8'h10);
        chk("t4_pass", pass1, 0);
        chk("t4_bus_mon", me, 0);

        // Restart with abort also high in IDLE: start wins.
        fmode  = 2'd0;
        abort1 = 1'b1;
        run1(-1, bc, dc, me, wc, ca, ba);
        chk("t5_busy_len", bc, 1026);
        chk("t5_pass", pass1, 1);
        chk("t5_err", err1, 0);
        chk("t5_faddr_clr", faddr1, 8'h00);

        // ECC double error at one R0 read of 0x20.
        derr_on = 1'b1;
        run1(-1, bc, dc, me, wc, ca, ba);
        derr_on = 1'b0;
`ifdef MEM_BIST_ECC_CHK_EN
        chk("t6_err", err1, 1);
        chk("t6_pass", pass1, 0);
        chk("t6_faddr", faddr1, 8'h20);
`else
        chk("t6_err", err1, 0);
        chk("t6_pass", pass1, 1);
`endif

        // Corrected-ECC flag alone never fails.
        corr_on = 1'b1;
        run1(-1, bc, dc, me, wc, ca, ba);
        corr_on = 1'b0;
        chk("t7_pass", pass1, 1);
        chk("t7_err", err1, 0);

        // Latency 3: 4*256+2*3 busy cycles; a start pulse while busy is ignored.
        bc = 0; dc = 0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            if (busy3) bc++;
            if (done3) dc++;
            start3 = (c == 100);
            @(negedge clk);
        end
        start3 = 1'b0;
        chk("t8_busy_len", bc, 1030);
        chk("t8_done_cnt", dc, 1);
        chk("t8_pass", pass3, 1);
        chk("t8_err", err3, 0);

        // Asynchronous reset mid-test: immediate idle, no done afterwards.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t9_busy_async", busy1, 0);
        chk("t9_cs_async", m1.cs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0; bc = 0;
        for (int c = 0; c < 1100; c++) begin
            if (done1) dc++;
            if (busy1) bc++;
            @(negedge clk);
        end
        chk("t9_no_done", dc, 0);
        chk("t9_no_busy", bc, 0);
        chk("t9_pass", pass1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
